// File: rtl/fb_port_arbiter.sv
// Framebuffer single-port arbiter: scan-out reads win, queued pixel writes retire on idle cycles.
// Optional framebuffer fill engine is built when FB_CLEAR_EN is defined.
module fb_port_arbiter #(
  parameter int ADDR_W     = 17,
  parameter int DATA_W     = 12,
  parameter int FB_SIZE    = 19200,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          rd_active,
  input  logic [ADDR_W-1:0]             rd_addr,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  input  logic [ADDR_W-1:0]             wr_addr,
  input  logic [DATA_W-1:0]             wr_data,
  input  logic                          clr_req,
  input  logic [DATA_W-1:0]             clr_color,
  output logic                          clr_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [7:0]                    err_cnt,
  output logic [ADDR_W-1:0]             ram_addr,
  output logic                          ram_we,
  output logic [DATA_W-1:0]             ram_wdata
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_req_t;

`ifdef FB_CLEAR_EN
  typedef enum logic [1:0] {IDLE, DRAIN, CLEAR} state_t;
`else
  typedef enum logic {IDLE, DRAIN} state_t;
`endif

  state_t              state_q, state_d;
  wr_req_t             fifo_q [FIFO_DEPTH];
  logic [PTR_W-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [LVL_W-1:0]    level_q, level_d;
  logic [7:0]          err_q, err_d;
  logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
  logic                ram_we_q, ram_we_d;
  logic [DATA_W-1:0]   ram_wdata_q, ram_wdata_d;
  logic                full, push_hs, in_range, push, pop, in_clear;
  wr_req_t             head;

`ifdef FB_CLEAR_EN
  logic [ADDR_W-1:0]   clr_ptr_q, clr_ptr_d;
  logic [DATA_W-1:0]   clr_color_q, clr_color_d;
  assign in_clear = (state_q == CLEAR);
`else
  logic unused_clr;
  assign unused_clr = ^{clr_req, clr_color};
  assign in_clear   = 1'b0;
`endif

  // Out-of-range pixels still complete the handshake so the writer never stalls on them.
  assign full     = (level_q == LVL_W'(FIFO_DEPTH));
  assign push_hs  = wr_valid && !full;
  assign in_range = (wr_addr < ADDR_W'(FB_SIZE));
  assign push     = push_hs && in_range;
  assign pop      = !rd_active && !in_clear && (level_q != '0);
  assign head     = fifo_q[rptr_q];

  always_comb begin
    state_d     = state_q;
    wptr_d      = push ? wptr_q + 1'b1 : wptr_q;
    rptr_d      = pop  ? rptr_q + 1'b1 : rptr_q;
    level_d     = level_q + LVL_W'(push) - LVL_W'(pop);
    err_d       = (push_hs && !in_range && err_q != 8'hFF) ? err_q + 8'd1 : err_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    ram_we_d    = 1'b0;
`ifdef FB_CLEAR_EN
    clr_ptr_d   = clr_ptr_q;
    clr_color_d = clr_color_q;
`endif

    if (rd_active) begin
      ram_addr_d = rd_addr;
`ifdef FB_CLEAR_EN
    end else if (in_clear) begin
      ram_addr_d  = clr_ptr_q;
      ram_wdata_d = clr_color_q;
      ram_we_d    = 1'b1;
`endif
    end else if (pop) begin
      ram_addr_d  = head.addr;
      ram_wdata_d = head.data;
      ram_we_d    = 1'b1;
    end

    case (state_q)
`ifdef FB_CLEAR_EN
      CLEAR: begin
        // Pointer only advances on cycles the reader leaves the port free.
        if (!rd_active) begin
          if (clr_ptr_q == ADDR_W'(FB_SIZE - 1))
            state_d = (level_d != '0) ? DRAIN : IDLE;
          else
            clr_ptr_d = clr_ptr_q + 1'b1;
        end
      end
`endif
      default: begin
        state_d = (level_d != '0) ? DRAIN : IDLE;
`ifdef FB_CLEAR_EN
        if (clr_req) begin
          state_d     = CLEAR;
          clr_ptr_d   = '0;
          clr_color_d = clr_color;
        end
`endif
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      wptr_q      <= '0;
      rptr_q      <= '0;
      level_q     <= '0;
      err_q       <= '0;
      ram_addr_q  <= '0;
      ram_we_q    <= 1'b0;
      ram_wdata_q <= '0;
`ifdef FB_CLEAR_EN
      clr_ptr_q   <= '0;
      clr_color_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      level_q     <= level_d;
      err_q       <= err_d;
      ram_addr_q  <= ram_addr_d;
      ram_we_q    <= ram_we_d;
      ram_wdata_q <= ram_wdata_d;
`ifdef FB_CLEAR_EN
      clr_ptr_q   <= clr_ptr_d;
      clr_color_q <= clr_color_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_q[wptr_q] <= '{addr: wr_addr, data: wr_data};
  end

  assign wr_ready   = !full;
  assign fifo_level = level_q;
  assign err_cnt    = err_q;
  assign ram_addr   = ram_addr_q;
  assign ram_we     = ram_we_q;
  assign ram_wdata  = ram_wdata_q;
`ifdef FB_CLEAR_EN
  assign clr_busy   = in_clear;
`else
  assign clr_busy   = 1'b0;
`endif

endmodule
